serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder: a+b+cin computed one bit per clock through a

---
 rtl/ra_pkg.sv | 14 +
 rtl/full_adder_1_bit.sv | 17 +
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ra_pkg.sv
// Shared definitions for the adder family (ripple-carry and bit-serial).
//   state_t  : control FSM encoding used by the sequential adders
//   RA_WIDTH : default operand/result width
package ra_pkg;

    localparam int RA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : ra_pkg

// File: rtl/full_adder_1_bit.sv
// Single-bit full adder, purely combinational.
// Ports:
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder_1_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1_bit

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder computing a + b + cin one bit per clock through
// a single full-adder cell. Operands are captured when start is accepted in
// IDLE, shifted LSB-first through the cell with the carry held in a
// flip-flop, and the registered result is presented with a one-cycle done
// pulse.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only in IDLE
//   a, b   : WIDTH-bit operands, captured on accept
//   cin    : carry-in, captured on accept
//   busy   : high whenever the FSM is not in IDLE
//   done   : single-cycle pulse; sum/cout valid from this cycle
//   sum    : registered result, held until the next completion
//   cout   : registered carry-out, held with sum
module serial_adder
    import ra_pkg::*;
#(
    parameter int WIDTH = RA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only the upper WIDTH-1 partial-sum bits need storing: the bit computed
    // on the final RUN cycle comes straight from the cell into sum.
    logic [WIDTH-2:0] s_sr;
    logic [WIDTH-1:0] s_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic fa_sum;
    logic fa_cout;

    full_adder_1_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New cell output enters at the MSB; after WIDTH shifts it is the full result.
    assign s_shift  = {fa_sum, s_sr};
    assign last_bit = (cnt == LAST_CNT);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned before the case so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/partial-sum shift registers, carry FF, counter
    // ------------------------------------------------------------------
    // NOTE: the shift registers are plain flops, not a RAM, so they take the
    // async reset like everything else and come out of reset cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_shift[WIDTH-1:1];
                    carry <= fa_cout;
                    // Park the counter at zero on the last bit rather than
                    // letting it wrap.
                    cnt   <= last_bit ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers: updated only on the last RUN edge, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == RUN && last_bit) begin
            sum  <= s_shift;
            cout <= fa_cout;
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): table-driven vectors plus
// hand-written sequences for start-while-busy, mid-RUN reset, back-to-back
// operations and a random sweep against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE: accept, wait for done (bounded),
    // capture the result, step through the DONE cycle back to IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick;                       // accepting edge
        start = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            tick;
            lat++;
        end
        rs = sum;
        rc = cout;
        tick;                       // leave DONE
        check("done_single_pulse", {30'b0, done, busy}, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           dcnt;
        int           k;
        logic         held_ok;
        logic [W:0]   ref_v;

        vecs[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[9] = '{8'h01, 8'hFE, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick;
        tick;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_sum_cout", {23'b0, cout, sum}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Idle with start low: nothing happens
        check("idle_stays", {30'b0, busy, done}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, rs, rc, lat);
            check($sformatf("vec%0d_sum", i), {24'b0, rs}, {24'b0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'b0, rc}, {31'b0, vecs[i].exp_cout});
            check($sformatf("vec%0d_latency", i), lat, W);
        end

        // Start held high, operands toggled every cycle during RUN
        a = 8'h3C; b = 8'h0F; cin = 1'b0; start = 1'b1;
        tick;
        dcnt = 0;
        k = 0;
        while (dcnt == 0 && k < 40) begin
            a = ~a; b = ~b; cin = ~cin;
            tick;
            k++;
            if (done) dcnt++;
        end
        start = 1'b0;
        check("held_start_latency", k, W);
        check("held_start_sum", {24'b0, sum}, 32'h4B);
        check("held_start_cout", {31'b0, cout}, 32'd0);
        tick;
        if (done) dcnt++;
        check("held_start_done_count", dcnt, 1);
        tick;

        // Reset mid-RUN: abort, outputs cleared at once, no done afterwards
        a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check("midrun_busy_before_rst", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {31'b0, busy}, 32'd0);
        check("midrun_rst_done", {31'b0, done}, 32'd0);
        check("midrun_rst_sum_cout", {23'b0, cout, sum}, 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done || busy) dcnt++;
        end
        check("midrun_rst_no_done", dcnt, 0);
        run_op(8'h12, 8'h34, 1'b0, rs, rc, lat);
        check("after_rst_sum", {24'b0, rs}, 32'h46);
        check("after_rst_cout", {31'b0, rc}, 32'd0);

        // Back-to-back: second start raised in the IDLE cycle after done
        run_op(8'h3C, 8'h0F, 1'b0, rs, rc, lat);
        check("b2b_first_sum", {24'b0, rs}, 32'h4B);
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        check("b2b_second_accepted", {31'b0, busy}, 32'd1);
        held_ok = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin
            if (sum !== 8'h4B || cout !== 1'b0) held_ok = 1'b0;
            tick;
            lat++;
        end
        check("b2b_prior_sum_held", {31'b0, held_ok}, 32'd1);
        check("b2b_second_latency", lat, W);
        check("b2b_second_result", {23'b0, cout, sum}, 32'h100);
        tick;
        tick;
        check("result_held_in_idle", {23'b0, cout, sum}, 32'h100);

        // Random sweep against the arithmetic reference
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            logic         rcin;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rcin = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            run_op(ra, rb, rcin, rs, rc, lat);
            check($sformatf("rand%0d_result", i), {23'b0, rc, rs}, {23'b0, ref_v});
            check($sformatf("rand%0d_latency", i), lat, W);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
